// File: rtl/ts_packet_transmitter.sv
// Serialises 188-byte TS packets from an upstream FIFO onto an 8-bit parallel TS port.
// Null packets (PID 0x1FFF) or idle slots fill the gaps when no full packet is queued.
module ts_packet_transmitter #(
    parameter int DIV = 8
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        NULL_EN,
    input  logic        PACKET_READY,
    input  logic [7:0]  FIFO_DATA,
    output logic        FIFO_RD_REQ,
    output logic [7:0]  TS_DATA,
    output logic        TS_DCLK,
    output logic        TS_VALID,
    output logic        TS_PSYNC,
    output logic [31:0] PKT_CNT,
    output logic [31:0] NULL_CNT,
    output logic [15:0] SYNC_ERR_CNT
);

    localparam int             PW        = $clog2(DIV);
    localparam logic [PW-1:0]  PH_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0]  PH_DECIDE = PW'(DIV - 2);
    localparam logic [PW-1:0]  PH_HALF   = PW'(DIV / 2);
    localparam logic [7:0]     LAST_IDX  = 8'd187;
    localparam logic [7:0]     SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        IDLE,
        SEND_FIFO,
        SEND_NULL
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  phase;
    logic [PW-1:0]  phase_next;
    logic [7:0]     byte_idx;
    logic           decide;
    logic           byte_edge;
    logic [7:0]     null_byte;
    logic [15:0]    sync_err_q;

    // byte_idx is the index of the next byte to be loaded, so it reads 0 during the
    // whole slot that shows byte 187: that slot is the packet-boundary decision point.
    always_comb begin
        phase_next  = (phase == PH_LAST) ? '0 : phase + 1'b1;
        byte_edge   = (phase == PH_LAST);
        decide      = (phase == PH_DECIDE) && ((state == IDLE) || (byte_idx == 8'd0));
        state_next  = state;
        FIFO_RD_REQ = 1'b0;
        if (decide) begin
            if (ENABLE && PACKET_READY) begin
                state_next = SEND_FIFO;
            end else if (ENABLE && NULL_EN) begin
                state_next = SEND_NULL;
            end else begin
                state_next = IDLE;
            end
        end
        if ((phase == PH_DECIDE) && (state_next == SEND_FIFO)) begin
            FIFO_RD_REQ = 1'b1;
        end
    end

    always_comb begin
        null_byte = 8'hFF;
        case (byte_idx)
            8'd0:    null_byte = SYNC_BYTE;
            8'd1:    null_byte = 8'h1F;
            8'd3:    null_byte = 8'h10;
            default: null_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TS_DCLK is registered from the next phase so it never glitches.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            phase   <= '0;
            TS_DCLK <= 1'b0;
        end else begin
            phase   <= phase_next;
            TS_DCLK <= (phase_next >= PH_HALF);
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            TS_DATA    <= 8'h00;
            TS_VALID   <= 1'b0;
            TS_PSYNC   <= 1'b0;
            byte_idx   <= 8'd0;
            PKT_CNT    <= 32'd0;
            NULL_CNT   <= 32'd0;
            sync_err_q <= 16'd0;
        end else if (byte_edge) begin
            case (state)
                SEND_FIFO: begin
                    TS_DATA  <= FIFO_DATA;
                    TS_VALID <= 1'b1;
                    TS_PSYNC <= (byte_idx == 8'd0);
                end
                SEND_NULL: begin
                    TS_DATA  <= null_byte;
                    TS_VALID <= 1'b1;
                    TS_PSYNC <= (byte_idx == 8'd0);
                end
                default: begin
                    TS_VALID <= 1'b0;
                    TS_PSYNC <= 1'b0;
                end
            endcase
            if (state != IDLE) begin
                byte_idx <= (byte_idx == LAST_IDX) ? 8'd0 : byte_idx + 8'd1;
            end
            if ((state == SEND_FIFO) && (byte_idx == 8'd0) &&
                (FIFO_DATA != SYNC_BYTE) && (sync_err_q != 16'hFFFF)) begin
                sync_err_q <= sync_err_q + 16'd1;
            end
            if (byte_idx == LAST_IDX) begin
                if (state == SEND_FIFO) begin
                    PKT_CNT <= PKT_CNT + 32'd1;
                end
                if (state == SEND_NULL) begin
                    NULL_CNT <= NULL_CNT + 32'd1;
                end
            end
        end
    end

    assign SYNC_ERR_CNT = sync_err_q;

endmodule

// File: tb/tb_ts_packet_transmitter.sv
// Directed bench for ts_packet_transmitter at DIV=4 with a non-showahead FIFO model
// and a receiver that samples the TS port on each rising TS_DCLK.
module tb_ts_packet_transmitter;

    localparam int DIV     = 4;
    localparam int PKT_LEN = 188;
    localparam int LIMIT   = 4000;

    localparam int K_NULL   = 0;
    localparam int K_COUNT  = 1;
    localparam int K_MULTI  = 2;
    localparam int K_BAD    = 3;
    localparam int K_TRIPLE = 4;
    localparam int K_DESC   = 5;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        null_en = 1'b0;
    logic        packet_ready = 1'b0;
    logic        ready_en = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_req;
    logic [7:0]  ts_data;
    logic        ts_dclk;
    logic        ts_valid;
    logic        ts_psync;
    logic [31:0] pkt_cnt;
    logic [31:0] null_cnt;
    logic [15:0] sync_err_cnt;

    logic [7:0]  fifo_q[$];
    logic [9:0]  rx[$];
    logic [7:0]  pkt[PKT_LEN];
    logic        rd_seen = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          rd_bad_phase = 0;
    int          dclk_bad = 0;
    int          cyc = 0;
    int          rd_base = 0;
    int          base = 0;

    ts_packet_transmitter #(.DIV(DIV)) dut (
        .SYS_CLK      (sys_clk),
        .RST          (rst),
        .ENABLE       (enable),
        .NULL_EN      (null_en),
        .PACKET_READY (packet_ready),
        .FIFO_DATA    (fifo_data),
        .FIFO_RD_REQ  (fifo_rd_req),
        .TS_DATA      (ts_data),
        .TS_DCLK      (ts_dclk),
        .TS_VALID     (ts_valid),
        .TS_PSYNC     (ts_psync),
        .PKT_CNT      (pkt_cnt),
        .NULL_CNT     (null_cnt),
        .SYNC_ERR_CNT (sync_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // cyc % DIV is the expected phase, derived only from clock edges since reset.
    always @(negedge sys_clk) begin
        rd_seen = fifo_rd_req;
        if (fifo_rd_req) begin
            rd_cnt++;
            if ((cyc % DIV) != DIV - 2) rd_bad_phase++;
        end
        if (rst && (ts_dclk !== ((cyc % DIV) >= DIV / 2))) dclk_bad++;
        packet_ready = ready_en && (fifo_q.size() >= PKT_LEN);
    end

    always @(posedge sys_clk) begin
        if (rd_seen && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end

    always @(posedge ts_dclk) rx.push_back({ts_valid, ts_psync, ts_data});

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic nen, input logic ren);
        @(negedge sys_clk);
        enable   = en;
        null_en  = nen;
        ready_en = ren;
    endtask

    task automatic waitSlots(input int n);
        repeat (n * DIV) @(posedge sys_clk);
        #1;
    endtask

    task automatic mark();
        #1;
        rd_base = rd_cnt;
        base    = rx.size();
    endtask

    task automatic makePkt(input int kind, input int n);
        for (int i = 0; i < PKT_LEN; i++) begin
            case (kind)
                K_NULL:   pkt[i] = (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF;
                K_COUNT:  pkt[i] = (i == 0) ? 8'h47 : 8'(i);
                K_MULTI:  pkt[i] = (i == 0) ? 8'h47 : 8'(128 + n * 32 + i);
                K_BAD:    pkt[i] = (i == 0) ? 8'h00 : (8'(i) ^ 8'h5A);
                K_TRIPLE: pkt[i] = (i == 0) ? 8'h47 : 8'(i * 3);
                default:  pkt[i] = (i == 0) ? 8'h47 : 8'(255 - i);
            endcase
        end
    endtask

    task automatic pushPkt();
        for (int i = 0; i < PKT_LEN; i++) fifo_q.push_back(pkt[i]);
    endtask

    function automatic logic [9:0] rxAt(input int idx);
        if (idx < 0 || idx >= rx.size()) return 'x;
        return rx[idx];
    endfunction

    function automatic int findStart(input int from);
        for (int i = from; i + 1 < rx.size(); i++) begin
            if (rx[i][9:8] == 2'b11 && rx[i][7:0] == pkt[0] && rx[i+1][7:0] == pkt[1]) return i;
        end
        return -1;
    endfunction

    function automatic int firstValid(input int from);
        for (int i = from; i < rx.size(); i++) begin
            if (rx[i][9]) return i;
        end
        return -1;
    endfunction

    task automatic compareRun(input string tag, input int start);
        int bad = 0;
        if (start < 0 || start + PKT_LEN > rx.size()) begin
            bad = PKT_LEN;
        end else begin
            for (int i = 0; i < PKT_LEN; i++) begin
                if (rx[start+i] !== {1'b1, (i == 0), pkt[i]}) bad++;
            end
        end
        checkOutput(tag, bad, 0);
    endtask

    task automatic waitCount(input string tag, input logic sel_null, input logic [31:0] target);
        int n = 0;
        while (((sel_null ? null_cnt : pkt_cnt) != target) && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput(tag, sel_null ? null_cnt : pkt_cnt, target);
    endtask

    initial begin
        int f;
        int p;
        int n;
        int tail;
        logic [9:0] entry;

        #1 rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_data", ts_data, 0);
        checkOutput("rst_flags", {ts_valid, ts_psync, ts_dclk, fifo_rd_req}, 0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 0);
        checkOutput("rst_null_cnt", null_cnt, 0);
        checkOutput("rst_sync_err", sync_err_cnt, 0);

        // Continuous null packets straight out of reset
        applyStimulus(1'b1, 1'b1, 1'b0);
        base = rx.size();
        rst  = 1'b1;
        waitCount("null_cnt_2", 1'b1, 2);
        waitSlots(2);
        f = firstValid(base);
        checkOutput("null_first_slot", f - base, 1);
        makePkt(K_NULL, 0);
        compareRun("null_pkt0", f);
        compareRun("null_pkt1", f + PKT_LEN);
        checkOutput("null_no_reads", rd_cnt, 0);

        // One FIFO packet inserted between nulls
        makePkt(K_COUNT, 0);
        pushPkt();
        mark();
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCount("pkt_cnt_1", 1'b0, 1);
        waitSlots(4);
        p = findStart(base);
        compareRun("fifo_pkt", p);
        checkOutput("fifo_reads", rd_cnt - rd_base, PKT_LEN);
        checkOutput("fifo_prev_null", rxAt(p - 1), {2'b10, 8'hFF});
        checkOutput("fifo_next_null0", rxAt(p + PKT_LEN), {2'b11, 8'h47});
        checkOutput("fifo_next_null1", rxAt(p + PKT_LEN + 1), {2'b10, 8'h1F});

        // Three queued packets back to back
        for (int k = 0; k < 3; k++) begin
            makePkt(K_MULTI, k);
            pushPkt();
        end
        mark();
        waitCount("pkt_cnt_4", 1'b0, 4);
        waitSlots(4);
        makePkt(K_MULTI, 0);
        p = findStart(base);
        for (int k = 0; k < 3; k++) begin
            makePkt(K_MULTI, k);
            compareRun($sformatf("multi_pkt%0d", k), p + PKT_LEN * k);
        end
        checkOutput("multi_reads", rd_cnt - rd_base, 3 * PKT_LEN);

        // Bad sync byte, then saturation of the error counter
        makePkt(K_BAD, 0);
        pushPkt();
        mark();
        waitCount("pkt_cnt_5", 1'b0, 5);
        waitSlots(4);
        p = findStart(base);
        compareRun("bad_sync_pkt", p);
        checkOutput("sync_err_1", sync_err_cnt, 1);
        force dut.sync_err_q = 16'hFFFF;
        #1 release dut.sync_err_q;
        #1 checkOutput("sync_err_forced", sync_err_cnt, 16'hFFFF);
        pushPkt();
        waitCount("pkt_cnt_6", 1'b0, 6);
        waitSlots(1);
        checkOutput("sync_err_sat", sync_err_cnt, 16'hFFFF);

        // ENABLE dropped mid-packet with NULL_EN low
        applyStimulus(1'b1, 1'b0, 1'b1);
        n = 0;
        while (ts_valid && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("idle_reached", ts_valid, 0);
        makePkt(K_TRIPLE, 0);
        pushPkt();
        mark();
        n = 0;
        while ((rd_cnt - rd_base) < 51 && n < LIMIT) begin
            @(posedge sys_clk);
            n++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCount("pkt_cnt_7", 1'b0, 7);
        waitSlots(20);
        p = findStart(base);
        compareRun("drop_pkt", p);
        checkOutput("drop_reads", rd_cnt - rd_base, PKT_LEN);
        entry = rxAt(p - 1);
        checkOutput("drop_prev_idle", entry[9], 0);
        tail = 0;
        for (int i = p + PKT_LEN; i < rx.size(); i++) if (rx[i][9]) tail++;
        checkOutput("drop_tail_valid", tail, 0);
        checkOutput("drop_ts_valid", ts_valid, 0);
        mark();
        waitSlots(10);
        checkOutput("idle_no_reads", rd_cnt - rd_base, 0);

        // Re-enable: next packet starts from idle at a decision point
        makePkt(K_DESC, 0);
        pushPkt();
        mark();
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitCount("pkt_cnt_8", 1'b0, 8);
        waitSlots(4);
        p = findStart(base);
        compareRun("reenable_pkt", p);
        entry = rxAt(p - 1);
        checkOutput("reenable_prev_idle", entry[9], 0);

        // Reset in the middle of a null packet
        applyStimulus(1'b1, 1'b1, 1'b0);
        n = 0;
        while (!ts_psync && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        waitSlots(100);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_data", ts_data, 0);
        checkOutput("midrst_flags", {ts_valid, ts_psync, ts_dclk, fifo_rd_req}, 0);
        checkOutput("midrst_counts", {pkt_cnt[7:0], null_cnt[7:0], sync_err_cnt}, 0);
        @(negedge sys_clk);
        base = rx.size();
        rst  = 1'b1;
        waitSlots(3);
        checkOutput("post_rst_slot0", rxAt(base), {2'b00, 8'h00});
        checkOutput("post_rst_slot1", rxAt(base + 1), {2'b11, 8'h47});
        checkOutput("post_rst_slot2", rxAt(base + 2), {2'b10, 8'h1F});

        checkOutput("dclk_shape", dclk_bad, 0);
        checkOutput("rd_phase", rd_bad_phase, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
